// File: rtl/ps2_key_encoder.sv
// ps2_key_encoder: PS/2 keyboard receiver plus scan-code folder.
// Deserialises raw PS/2 frames and merges E0/F0 prefixes into one 11-bit
// ps2_key event {toggle, pressed, extended, code}. Bit 10 flips once per key.
module ps2_key_encoder #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 40000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ps2_clk_in,
  input  logic        ps2_dat_in,
  output logic [10:0] ps2_key,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int IW = $clog2(TIMEOUT + 1);

  typedef enum logic {NORMAL, SKIP} dec_st_t;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          clk_filt, clk_filt_q;
  logic [FW-1:0] filt_cnt;
  logic [IW-1:0] idle_cnt;
  logic [3:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par;
  logic          fall;
  logic          ext, brk;
  logic [2:0]    skip_cnt;
  dec_st_t       state;
  logic          is_resp;

  // Two-flop synchronisers; idle bus level is high
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      {clk_s1, clk_s2} <= 2'b11;
      {dat_s1, dat_s2} <= 2'b11;
    end else begin
      clk_s1 <= ps2_clk_in;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_dat_in;
      dat_s2 <= dat_s1;
    end
  end

  // Glitch filter: follow the synced clock only after FILTER_LEN stable cycles
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_filt   <= 1'b1;
      clk_filt_q <= 1'b1;
      filt_cnt   <= '0;
    end else begin
      clk_filt_q <= clk_filt;
      if (clk_s2 == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign fall = clk_filt_q & ~clk_filt;

  // Frame deserialiser with idle timeout; strobes are single-cycle
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      par        <= 1'b0;
      idle_cnt   <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fall) begin
        idle_cnt <= '0;
        if (bit_cnt == 4'd0) begin
          // a high start sample is line noise, not a frame
          if (!dat_s2) bit_cnt <= 4'd1;
        end else if (bit_cnt <= 4'd8) begin
          shreg   <= {dat_s2, shreg[7:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end else if (bit_cnt == 4'd9) begin
          par     <= dat_s2;
          bit_cnt <= 4'd10;
        end else begin
          if ((^{shreg, par}) && dat_s2) begin
            byte_data  <= shreg;
            byte_valid <= 1'b1;
          end else begin
            frame_err  <= 1'b1;
          end
          bit_cnt <= '0;
        end
      end else begin
        if (idle_cnt != IW'(TIMEOUT)) idle_cnt <= idle_cnt + 1'b1;
        // saturated idle counter plus cleared bit_cnt gives a single strobe
        if (bit_cnt != 4'd0 && idle_cnt == IW'(TIMEOUT)) begin
          bit_cnt   <= '0;
          frame_err <= 1'b1;
        end
      end
    end
  end

  // Device responses that are never key codes when no prefix is pending
  always_comb begin
    is_resp = 1'b0;
    case (byte_data)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: is_resp = 1'b1;
      default: is_resp = 1'b0;
    endcase
  end

  // Scan-code decoder: fold prefixes, swallow Pause, emit one event per key
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= NORMAL;
      ext      <= 1'b0;
      brk      <= 1'b0;
      skip_cnt <= '0;
      ps2_key  <= '0;
    end else if (byte_valid) begin
      case (state)
        NORMAL: begin
          if (byte_data == 8'hE0) begin
            ext <= 1'b1;
          end else if (byte_data == 8'hF0) begin
            brk <= 1'b1;
          end else if (byte_data == 8'hE1) begin
            state    <= SKIP;
            skip_cnt <= 3'd7;
          end else if (!(is_resp && !ext && !brk)) begin
            ps2_key <= {~ps2_key[10], ~brk, ext, byte_data};
            ext     <= 1'b0;
            brk     <= 1'b0;
          end
        end
        SKIP: begin
          skip_cnt <= skip_cnt - 3'd1;
          if (skip_cnt == 3'd1) state <= NORMAL;
        end
        default: state <= NORMAL;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Bench for ps2_key_encoder: bit-banged PS/2 frames, scoreboard queues of
// expected bytes and key words checked as the DUT strobes them.
module tb_ps2_key_encoder;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 1000;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic        ps2_clk_in = 1'b1;
  logic        ps2_dat_in = 1'b1;
  logic [10:0] ps2_key;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        frame_err;

  int total = 0;
  int bad   = 0;
  int err_seen = 0;
  logic [7:0]  exp_bytes[$];
  logic [10:0] exp_keys[$];
  logic [10:0] last_key = '0;
  logic        prev_valid = 1'b0;

  ps2_key_encoder #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
    .ps2_key(ps2_key), .byte_valid(byte_valid),
    .byte_data(byte_data), .frame_err(frame_err)
  );

  always #5 clk_sys = ~clk_sys;

  // one cycle, sampled 1 time unit after the edge, with scoreboard checks
  task automatic tick();
    logic [7:0]  eb;
    logic [10:0] ek;
    @(posedge clk_sys); #1;
    if (byte_valid) begin
      total++;
      if (exp_bytes.size() == 0) begin
        bad++; $display("FAIL byte_unexpected: got %h, none expected", byte_data);
      end else begin
        eb = exp_bytes.pop_front();
        if (byte_data !== eb) begin
          bad++; $display("FAIL byte_data: got %h expected %h", byte_data, eb);
        end
      end
    end
    if (frame_err) err_seen++;
    if (ps2_key !== last_key) begin
      total++;
      if (exp_keys.size() == 0) begin
        bad++; $display("FAIL key_unexpected: got %h, none expected", ps2_key);
      end else begin
        ek = exp_keys.pop_front();
        if (ps2_key !== ek) begin
          bad++; $display("FAIL ps2_key: got %h expected %h", ps2_key, ek);
        end
      end
      total++;
      if (!prev_valid) begin
        bad++; $display("FAIL key_timing: key %h changed without byte_valid the cycle before", ps2_key);
      end
      last_key = ps2_key;
    end
    prev_valid = byte_valid;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // one PS/2 bit: data set while clock high, sampled at the falling edge
  task automatic send_bit(input logic b, input logic glitch);
    ps2_dat_in = b;
    ticks(10);
    if (glitch) begin
      ps2_clk_in = 1'b0; ticks(FILTER_LEN - 2);
      ps2_clk_in = 1'b1; ticks(10);
    end
    ps2_clk_in = 1'b0; ticks(20);
    ps2_clk_in = 1'b1; ticks(10);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par, input int glitch_bit);
    send_bit(1'b0, glitch_bit == 0);
    for (int i = 0; i < 8; i++) send_bit(d[i], glitch_bit == i + 1);
    send_bit((~^d) ^ bad_par, glitch_bit == 9);
    send_bit(1'b1, glitch_bit == 10);
    ps2_dat_in = 1'b1;
    ticks(50);
  endtask

  task automatic send_good(input logic [7:0] d);
    exp_bytes.push_back(d);
    send_frame(d, 1'b0, -1);
  endtask

  task automatic drained(input string name);
    total++;
    if (exp_bytes.size() != 0 || exp_keys.size() != 0) begin
      bad++; $display("FAIL %s_drain: bytes left %0d keys left %0d, required 0/0",
                      name, exp_bytes.size(), exp_keys.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk_sys);
    #1;
    total++; if (ps2_key !== 11'h000) begin bad++; $display("FAIL reset_key: got %h expected 000", ps2_key); end
    total++; if (byte_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", byte_valid); end
    total++; if (byte_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h expected 00", byte_data); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b expected 0", frame_err); end
    reset = 1'b0;
    last_key = 11'h000;
    prev_valid = 1'b0;
    ticks(20);
  endtask

  task automatic test_make();
    exp_keys.push_back(11'h61C);
    send_good(8'h1C);
    drained("make");
  endtask

  task automatic test_ext_break();
    exp_keys.push_back(11'h175);
    send_good(8'hE0);
    send_good(8'hF0);
    send_good(8'h75);
    drained("ext_break");
  endtask

  task automatic test_parity_err();
    int e0 = err_seen;
    send_frame(8'h1C, 1'b1, -1);
    total++;
    if (err_seen - e0 != 1) begin bad++; $display("FAIL parity_err: got %0d strobes expected 1", err_seen - e0); end
    total++;
    if (ps2_key !== 11'h175) begin bad++; $display("FAIL parity_key: got %h expected 175", ps2_key); end
    drained("parity");
  endtask

  task automatic test_timeout();
    int e0 = err_seen;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    ticks(TIMEOUT + 10);
    total++;
    if (err_seen - e0 != 1) begin bad++; $display("FAIL timeout_err: got %0d strobes expected 1", err_seen - e0); end
    exp_keys.push_back(11'h629);
    send_good(8'h29);
    drained("timeout");
  endtask

  task automatic test_glitch();
    int e0 = err_seen;
    exp_bytes.push_back(8'h34);
    exp_keys.push_back(11'h234);
    send_frame(8'h34, 1'b0, 4);
    total++;
    if (err_seen != e0) begin bad++; $display("FAIL glitch_err: got %0d strobes expected 0", err_seen - e0); end
    drained("glitch");
  endtask

  task automatic test_pause_bat();
    logic [7:0] seq [10] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'hAA, 8'h6B};
    exp_keys.push_back(11'h66B);
    for (int i = 0; i < 10; i++) send_good(seq[i]);
    drained("pause_bat");
  endtask

  task automatic test_f0_e0_order();
    exp_keys.push_back(11'h174);
    send_good(8'hF0);
    send_good(8'hE0);
    send_good(8'h74);
    drained("f0_e0");
  endtask

  task automatic test_reset_midframe();
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    test_reset();
    exp_keys.push_back(11'h61C);
    send_good(8'h1C);
    drained("reset_mid");
  endtask

  initial begin
    test_reset();
    test_make();
    test_ext_break();
    test_parity_err();
    test_timeout();
    test_glitch();
    test_pause_bat();
    test_f0_e0_order();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
